trace_stream_arbiter: RTL and testbench

- Shares the single character input of cpu_checker between two trace producers, e.g. a GRF-write trace and a DM-write trace.
- Each producer emits ASCII messages framed '^' … '#'. Example: "^338@00003130: $ 8 <= fffb528#".
- Grants the checker to one producer for a whole message, so characters from different producers never interleave.
- Recovers from a stalled producer by aborting its message.
- Sits between the trace sources and cpu_checker; drives the checker's char input.

---
 rtl/trace_stream_arbiter.sv | 135 +++++++++++++
 tb/tb_trace_stream_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_arbiter.sv
// ============================================================================
// Module   : trace_stream_arbiter
// Purpose  : Shares one checker character input between two '^'...'#' framed
//            trace producers. Messages are granted whole, never interleaved.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trace_stream_arbiter #(
    parameter int unsigned STALL_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req0_char,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_char,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] char,
    output logic       char_valid,
    output logic       grant,
    output logic       busy,
    output logic       msg_done,
    output logic [7:0] abort_cnt
);

    localparam logic [7:0] SOF        = 8'h5E;
    localparam logic [7:0] EOF        = 8'h23;
    localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t     state;
    logic       rr_ptr;
    logic [7:0] stall_cnt;

    logic       any_valid;
    logic       cand;
    logic       src;
    logic [7:0] src_char;
    logic       take;

    // Ready is a pure function of registered state plus the live valids;
    // it is forced low while reset is held.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        cand       = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    req0_ready = any_valid & ~cand;
                    req1_ready = any_valid &  cand;
                end
                LOCK: begin
                    req0_ready = ~grant;
                    req1_ready =  grant;
                end
                default: ;
            endcase
        end
        src      = (state == LOCK) ? grant : cand;
        src_char = src ? req1_char : req0_char;
        take     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    end

    assign busy = (state == LOCK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            char       <= 8'h00;
            char_valid <= 1'b0;
            grant      <= 1'b0;
            msg_done   <= 1'b0;
            abort_cnt  <= 8'h00;
            rr_ptr     <= 1'b0;
            stall_cnt  <= 8'h00;
        end else begin
            char_valid <= 1'b0;
            msg_done   <= 1'b0;
            case (state)
                IDLE: begin
                    // Non-'^' characters are swallowed to resynchronise on a frame start.
                    if (take && src_char == SOF) begin
                        char       <= src_char;
                        char_valid <= 1'b1;
                        grant      <= src;
                        stall_cnt  <= 8'h00;
                        state      <= LOCK;
                    end
                end
                LOCK: begin
                    if (take) begin
                        char       <= src_char;
                        char_valid <= 1'b1;
                        stall_cnt  <= 8'h00;
                        if (src_char == EOF) begin
                            msg_done <= 1'b1;
                            rr_ptr   <= ~grant;
                            state    <= IDLE;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        // The NUL emitted here is visible during the ABORT cycle itself.
                        char       <= 8'h00;
                        char_valid <= 1'b1;
                        stall_cnt  <= 8'h00;
                        rr_ptr     <= ~grant;
                        if (abort_cnt != 8'hFF) begin
                            abort_cnt <= abort_cnt + 8'd1;
                        end
                        state      <= ABORT;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trace_stream_arbiter.sv
// ============================================================================
// Module   : tb_trace_stream_arbiter
// Purpose  : Directed self-checking bench for trace_stream_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_trace_stream_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req0_char = 8'h00;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_char = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] char;
    logic       char_valid;
    logic       grant;
    logic       busy;
    logic       msg_done;
    logic [7:0] abort_cnt;

    int    n_checks = 0;
    int    n_pass   = 0;
    string log_s    = "";
    string gr_s     = "";
    string one_c    = " ";
    int    done_cnt = 0;
    int    md_err   = 0;

    trace_stream_arbiter #(.STALL_MAX(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_char  (req0_char),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_char  (req1_char),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .char       (char),
        .char_valid (char_valid),
        .grant      (grant),
        .busy       (busy),
        .msg_done   (msg_done),
        .abort_cnt  (abort_cnt)
    );

    always #5 clk = ~clk;

    // Output log: forwarded characters (NUL shown as '~') and owning source.
    always @(negedge clk) begin
        if (char_valid) begin
            one_c    = " ";
            one_c[0] = (char == 8'h00) ? 8'h7E : char;
            log_s    = {log_s, one_c};
            gr_s     = {gr_s, grant ? "1" : "0"};
        end
        if (msg_done) begin
            done_cnt++;
            if (!(char_valid && char == 8'h23)) md_err++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        log_s    = "";
        gr_s     = "";
        done_cnt = 0;
        md_err   = 0;
        reset    = 1'b1;
    endtask

    // Presents a string on one source; optionally checks each forwarded char
    // one cycle after its acceptance edge.
    task automatic send(input int src, input string s, input bit chk);
        int lat_err = 0;
        for (int i = 0; i < s.len(); i++) begin
            bit acc = 1'b0;
            if (src == 0) begin req0_char = s[i]; req0_valid = 1'b1; end
            else          begin req1_char = s[i]; req1_valid = 1'b1; end
            for (int t = 0; t < 300 && !acc; t++) begin
                #1;
                if ((src == 0) ? req0_ready : req1_ready) begin
                    acc = 1'b1;
                    @(negedge clk);
                    if (chk) begin
                        #1;
                        if (!(char_valid === 1'b1 && char === s[i] &&
                              busy === (s[i] != 8'h23) && msg_done === (s[i] == 8'h23)))
                            lat_err++;
                    end
                end else begin
                    @(negedge clk);
                end
            end
            if (!acc) begin
                n_checks++;
                $display("FAIL send_timeout src=%0d idx=%0d: got no ready, expected ready within 300 cycles", src, i);
                break;
            end
        end
        if (src == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        if (chk) begin
            n_checks++;
            if (lat_err !== 0) $display("FAIL latency_busy_done src=%0d: got %0d bad cycles, expected 0", src, lat_err);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        req0_char = 8'h5E; req0_valid = 1'b1;
        req1_char = 8'h5E; req1_valid = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (char !== 8'h00) $display("FAIL reset_char: got %h, expected 00", char); else n_pass++;
        n_checks++; if (char_valid !== 1'b0) $display("FAIL reset_char_valid: got %b, expected 0", char_valid); else n_pass++;
        n_checks++; if (grant !== 1'b0) $display("FAIL reset_grant: got %b, expected 0", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (msg_done !== 1'b0) $display("FAIL reset_msg_done: got %b, expected 0", msg_done); else n_pass++;
        n_checks++; if (abort_cnt !== 8'h00) $display("FAIL reset_abort_cnt: got %0d, expected 0", abort_cnt); else n_pass++;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b, expected 00", {req0_ready, req1_ready}); else n_pass++;
    endtask

    task automatic test_single();
        string m = "^338@00003130: $ 8 <= fffb528#";
        string z = "";
        for (int i = 0; i < m.len(); i++) z = {z, "0"};
        do_reset();
        send(0, m, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++; if (log_s != m) $display("FAIL single_stream: got \"%s\", expected \"%s\"", log_s, m); else n_pass++;
        n_checks++; if (gr_s != z) $display("FAIL single_grant: got %s, expected %s", gr_s, z); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL single_msg_done_count: got %0d, expected 1", done_cnt); else n_pass++;
        n_checks++; if (md_err !== 0) $display("FAIL single_msg_done_align: got %0d, expected 0", md_err); else n_pass++;
    endtask

    task automatic test_contention();
        int viol = 0;
        do_reset();
        fork
            send(0, "^ab#", 1'b0);
            send(1, "^cd#", 1'b0);
            begin
                for (int t = 0; t < 100 && done_cnt == 0; t++) begin
                    @(negedge clk);
                    #2;
                    if (done_cnt == 0 && req1_ready) viol++;
                end
            end
        join
        repeat (3) @(negedge clk);
        n_checks++; if (log_s != "^ab#^cd#") $display("FAIL contention_stream: got \"%s\", expected \"^ab#^cd#\"", log_s); else n_pass++;
        n_checks++; if (gr_s != "00001111") $display("FAIL contention_grant: got %s, expected 00001111", gr_s); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL contention_ready1_early: got %0d cycles, expected 0", viol); else n_pass++;
        n_checks++; if (done_cnt !== 2) $display("FAIL contention_msg_done_count: got %0d, expected 2", done_cnt); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        fork
            begin send(0, "^a0#", 1'b0); send(0, "^a1#", 1'b0); send(0, "^a2#", 1'b0); end
            begin send(1, "^b0#", 1'b0); send(1, "^b1#", 1'b0); send(1, "^b2#", 1'b0); end
        join
        repeat (3) @(negedge clk);
        n_checks++; if (log_s != "^a0#^b0#^a1#^b1#^a2#^b2#") $display("FAIL rr_order: got \"%s\", expected \"^a0#^b0#^a1#^b1#^a2#^b2#\"", log_s); else n_pass++;
        n_checks++; if (gr_s != "000011110000111100001111") $display("FAIL rr_grant: got %s, expected 000011110000111100001111", gr_s); else n_pass++;
        n_checks++; if (done_cnt !== 6) $display("FAIL rr_msg_done_count: got %0d, expected 6", done_cnt); else n_pass++;
    endtask

    task automatic test_resync();
        do_reset();
        send(0, "12a^*00003130 <= 1#", 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (log_s != "^*00003130 <= 1#") $display("FAIL resync_stream: got \"%s\", expected \"^*00003130 <= 1#\"", log_s); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL resync_msg_done_count: got %0d, expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_stall_abort();
        do_reset();
        fork
            begin
                send(0, "^338@", 1'b0);
                repeat (15) @(negedge clk);
                #1;
                n_checks++; if ({busy, char_valid} !== 2'b10) $display("FAIL stall_before_expiry: got busy,valid=%b, expected 10", {busy, char_valid}); else n_pass++;
                @(negedge clk);
                #1;
                n_checks++; if ({char_valid, char} !== 9'h100) $display("FAIL abort_char: got valid=%b char=%h, expected valid=1 char=00", char_valid, char); else n_pass++;
                n_checks++; if (abort_cnt !== 8'd1) $display("FAIL abort_cnt: got %0d, expected 1", abort_cnt); else n_pass++;
                n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b, expected 0", busy); else n_pass++;
                n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL abort_ready: got %b, expected 00", {req0_ready, req1_ready}); else n_pass++;
            end
            send(1, "^x#", 1'b0);
        join
        repeat (3) @(negedge clk);
        n_checks++; if (log_s != "^338@~^x#") $display("FAIL abort_stream: got \"%s\", expected \"^338@~^x#\"", log_s); else n_pass++;
        n_checks++; if (gr_s != "000000111") $display("FAIL abort_grant: got %s, expected 000000111", gr_s); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(1, "^338", 1'b0);
        #2;
        n_checks++; if ({char_valid, busy, grant, char} !== {3'b111, 8'h38}) $display("FAIL mid_pre_reset: got valid,busy,grant=%b char=%h, expected 111 char=38", {char_valid, busy, grant}, char); else n_pass++;
        req0_char = 8'h5E; req0_valid = 1'b1;
        req1_char = 8'h5E; req1_valid = 1'b1;
        reset = 1'b0;
        #1;
        n_checks++; if ({char_valid, busy, grant, msg_done} !== 4'b0000) $display("FAIL mid_reset_flags: got %b, expected 0000", {char_valid, busy, grant, msg_done}); else n_pass++;
        n_checks++; if (char !== 8'h00) $display("FAIL mid_reset_char: got %h, expected 00", char); else n_pass++;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL mid_reset_ready: got %b, expected 00", {req0_ready, req1_ready}); else n_pass++;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        log_s      = "";
        gr_s       = "";
        done_cnt   = 0;
        reset      = 1'b1;
        send(0, "^9#", 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (log_s != "^9#") $display("FAIL mid_after_release: got \"%s\", expected \"^9#\"", log_s); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL mid_msg_done_count: got %0d, expected 1", done_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_resync();
        test_stall_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
